// File: rtl/vslc_spi_eeprom_fetch.sv
// vslc_spi_eeprom_fetch: SPI mode-0 sequential reader for 25xx EEPROMs.
// Sends READ plus a start address, then streams bytes to the VSLC core.
module vslc_spi_eeprom_fetch #(
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter int         GAP_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        spi_div,
  input  logic              restart,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              hold_n,
  input  logic              cipo,
  output logic              copi,
  output logic              sck,
  output logic              cs_n,
  output logic              sd_oe,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic [ADDR_W-1:0] byte_addr,
  output logic [3:0]        bit_index
);

  localparam int TX_W = 8 + ADDR_W;
  localparam int CW   = $clog2(ADDR_W) + 1;

  typedef enum logic [2:0] {
    GAP,
    CMD,
    ADDR,
    DATA,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  state_t            resume_q, resume_d;
  state_t            eff;
  logic [7:0]        div_q, div_d;
  logic [7:0]        gap_q, gap_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     last_idx;
  logic              last_q, last_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [6:0]        rx_q, rx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cur_addr;
  logic              load_q, load_d;
  logic              sck_q, sck_d;
  logic              cs_n_q, cs_n_d;
  logic              copi_q, copi_d;
  logic              oe_q, oe_d;
  logic              bv_q, bv_d;
  logic [7:0]        bdata_q, bdata_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;

  logic tick;
  logic in_gap;
  logic fall;
  logic rise;

  assign tick   = div_q >= spi_div;
  assign in_gap = state_q == GAP;
  assign fall   = !in_gap && sck_q;
  assign rise   = !in_gap && !sck_q;

  // HOLD resumes into the interrupted field on the same tick
  assign eff = (state_q == HOLD) ? resume_q : state_q;

  assign last_idx = (eff == ADDR) ? CW'(ADDR_W - 1) : CW'(7);

  // address is latched one clk after reset release
  assign cur_addr = load_q ? start_addr : addr_q;

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    div_d    = tick ? 8'd0 : div_q + 8'd1;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    addr_d   = addr_q;
    load_d   = 1'b0;
    sck_d    = sck_q;
    cs_n_d   = cs_n_q;
    copi_d   = copi_q;
    oe_d     = oe_q;
    bv_d     = 1'b0;
    bdata_d  = bdata_q;
    baddr_d  = baddr_q;

    if (load_q) begin
      addr_d = start_addr;
    end

    if (tick) begin
      unique case (1'b1)
        in_gap: begin
          sck_d  = 1'b0;
          cs_n_d = 1'b1;
          if (gap_q == 8'(GAP_TICKS - 1)) begin
            state_d = CMD;
            gap_d   = 8'd0;
            cs_n_d  = 1'b0;
            oe_d    = 1'b1;
            tx_d    = {CMD_READ, cur_addr};
            copi_d  = CMD_READ[7];
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
        fall: begin
          sck_d = 1'b0;
          if (state_q != DATA) begin
            last_d = 1'b0;
            if (last_q && state_q == ADDR) begin
              state_d = DATA;
              copi_d  = 1'b0;
              oe_d    = 1'b0;
            end else begin
              tx_d   = tx_q << 1;
              copi_d = tx_q[TX_W-2];
              if (last_q) begin
                state_d = ADDR;
              end
            end
          end
        end
        rise && !hold_n: begin
          if (state_q != HOLD) begin
            resume_d = state_q;
          end
          state_d = HOLD;
        end
        default: begin
          state_d = eff;
          sck_d   = 1'b1;
          rx_d    = {rx_q[5:0], cipo};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == last_idx) begin
            cnt_d = '0;
            if (eff == DATA) begin
              bv_d    = 1'b1;
              bdata_d = {rx_q, cipo};
              baddr_d = addr_q;
              addr_d  = addr_q + ADDR_W'(1);
            end else begin
              last_d = 1'b1;
            end
          end
        end
      endcase
    end

    // a byte finishing on this clk keeps its strobe
    if (restart) begin
      state_d = GAP;
      addr_d  = start_addr;
      load_d  = 1'b0;
      div_d   = 8'd0;
      gap_d   = 8'd0;
      cnt_d   = '0;
      last_d  = 1'b0;
      sck_d   = 1'b0;
      cs_n_d  = 1'b1;
      copi_d  = 1'b0;
      oe_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= GAP;
      resume_q <= GAP;
      div_q    <= 8'd0;
      gap_q    <= 8'd0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      addr_q   <= '0;
      load_q   <= 1'b1;
      sck_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      copi_q   <= 1'b0;
      oe_q     <= 1'b0;
      bv_q     <= 1'b0;
      bdata_q  <= 8'd0;
      baddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      div_q    <= div_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      addr_q   <= addr_d;
      load_q   <= load_d;
      sck_q    <= sck_d;
      cs_n_q   <= cs_n_d;
      copi_q   <= copi_d;
      oe_q     <= oe_d;
      bv_q     <= bv_d;
      bdata_q  <= bdata_d;
      baddr_q  <= baddr_d;
    end
  end

  assign sck        = sck_q;
  assign cs_n       = cs_n_q;
  assign copi       = copi_q;
  assign sd_oe      = oe_q;
  assign byte_valid = bv_q;
  assign byte_data  = bdata_q;
  assign byte_addr  = baddr_q;
  assign bit_index  = cnt_q[3:0];

endmodule

// File: tb/tb_vslc_spi_eeprom_fetch.sv
// Bench for vslc_spi_eeprom_fetch: EEPROM model plus byte scoreboard.
// Directed sequences push expected bytes; a monitor pops on byte_valid.
module tb_vslc_spi_eeprom_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  spi_div = 8'd0;
  logic        restart = 1'b0;
  logic [15:0] start_addr = 16'h0000;
  logic        hold_n = 1'b1;
  logic        cipo = 1'b0;
  logic        copi;
  logic        sck;
  logic        cs_n;
  logic        sd_oe;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [15:0] byte_addr;
  logic [3:0]  bit_index;

  always #5 clk = ~clk;

  vslc_spi_eeprom_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_div    (spi_div),
    .restart    (restart),
    .start_addr (start_addr),
    .hold_n     (hold_n),
    .cipo       (cipo),
    .copi       (copi),
    .sck        (sck),
    .cs_n       (cs_n),
    .sd_oe      (sd_oe),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_addr  (byte_addr),
    .bit_index  (bit_index)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } byte_t;

  byte_t       exp_q[$];
  logic [15:0] hdr_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_bv = 0;
  time         t_prev = 0;
  time         t_last = 0;
  byte_t       mon_e;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0000: mem_byte = 8'hA5;
      16'h0001: mem_byte = 8'h3C;
      default:  mem_byte = a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && byte_valid === 1'b1) begin
      t_prev = t_last;
      t_last = $time;
      n_bv++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_byte: got addr 0x%0h data 0x%0h, required none",
                 byte_addr, byte_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("byte_addr", 32'(byte_addr), 32'(mon_e.a));
        check("byte_data", 32'(byte_data), 32'(mon_e.d));
      end
    end
  end

  // EEPROM model: captures opcode/address, shifts data out on sck fall
  int          n_rise = 0;
  int          mk;
  logic [23:0] hdr = '0;
  logic [15:0] base = '0;
  logic [7:0]  mb;
  logic        oe_bad = 1'b0;

  always @(posedge cs_n) begin
    n_rise = 0;
    oe_bad = 1'b0;
  end

  always @(posedge sck) begin
    if (cs_n === 1'b0) begin
      if (n_rise < 24) begin
        hdr = {hdr[22:0], copi};
        if (sd_oe !== 1'b1) oe_bad = 1'b1;
      end
      n_rise++;
      if (n_rise == 24) begin
        base = hdr[15:0];
        check("read_opcode", 32'(hdr[23:16]), 32'h03);
        check("sd_oe_header", 32'(oe_bad), 32'd0);
        if (hdr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_header: got addr 0x%0h, required none",
                   hdr[15:0]);
        end else begin
          check("read_addr", 32'(hdr[15:0]), 32'(hdr_q.pop_front()));
        end
      end
      if (n_rise == 25) check("sd_oe_data", 32'(sd_oe), 32'd0);
    end
  end

  always @(negedge sck) begin
    if (cs_n === 1'b0 && n_rise >= 24) begin
      mk = n_rise - 24;
      mb = mem_byte(base + 16'(mk / 8));
      cipo = mb[7 - (mk % 8)];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bv(input int target, input int budget);
    int k = 0;
    while (n_bv < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (n_bv < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_bv: got %0d strobes, required %0d", n_bv, target);
    end
  endtask

  task automatic measure(input logic lvl, output int n);
    int k = 0;
    while (sck == lvl && k < 1000) begin
      step();
      k++;
    end
    k = 0;
    while (sck != lvl && k < 1000) begin
      step();
      k++;
    end
    n = 0;
    while (sck == lvl && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs_n"}, 32'(cs_n), 32'd1);
    check({tag, "_sck"}, 32'(sck), 32'd0);
    check({tag, "_copi"}, 32'(copi), 32'd0);
    check({tag, "_sd_oe"}, 32'(sd_oe), 32'd0);
    check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_byte_data"}, 32'(byte_data), 32'd0);
    check({tag, "_byte_addr"}, 32'(byte_addr), 32'd0);
    check({tag, "_bit_index"}, 32'(bit_index), 32'd0);
  endtask

  initial begin
    int n;
    int k;
    #1 rst_n = 1'b0;
    #11;
    check_reset_vals("reset");

    hdr_q.push_back(16'h0000);
    exp_q.push_back('{a: 16'h0000, d: 8'hA5});
    exp_q.push_back('{a: 16'h0001, d: 8'h3C});
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("cs_n_after_1clk", 32'(cs_n), 32'd1);
    step();
    check("cs_n_after_2clk", 32'(cs_n), 32'd0);
    check("sd_oe_cmd", 32'(sd_oe), 32'd1);
    check("copi_cmd_msb", 32'(copi), 32'd0);
    wait_bv(2, 200);
    check("byte_gap_div0", 32'((t_last - t_prev) / 10), 32'd16);

    spi_div = 8'd3;
    exp_q.push_back('{a: 16'h0002, d: 8'h58});
    exp_q.push_back('{a: 16'h0003, d: 8'h59});
    wait_bv(3, 400);
    measure(1'b1, n);
    check("sck_high_clks", 32'(n), 32'd4);
    measure(1'b0, n);
    check("sck_low_clks", 32'(n), 32'd4);
    wait_bv(4, 800);
    check("byte_gap_div3", 32'((t_last - t_prev) / 10), 32'd64);

    spi_div = 8'd0;
    exp_q.push_back('{a: 16'h0004, d: 8'h5E});
    wait_bv(5, 400);
    k = 0;
    while (bit_index != 4'd4 && k < 100) begin
      step();
      k++;
    end
    check("bit_index_at_restart", 32'(bit_index), 32'd4);
    hdr_q.push_back(16'h0123);
    exp_q.push_back('{a: 16'h0123, d: 8'h78});
    exp_q.push_back('{a: 16'h0124, d: 8'h7F});
    start_addr = 16'h0123;
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_sck", 32'(sck), 32'd0);
    n = 0;
    while (cs_n == 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("cs_n_gap_ge2", 32'(n + 1 >= 2), 32'd1);
    wait_bv(6, 200);

    k = 0;
    while (!(bit_index == 4'd3 && sck == 1'b0) && k < 100) begin
      step();
      k++;
    end
    hold_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 10) begin
        check("hold_sck", 32'(sck), 32'd0);
        check("hold_cs_n", 32'(cs_n), 32'd0);
        check("hold_bit_index", 32'(bit_index), 32'd3);
        check("hold_no_valid", 32'(byte_valid), 32'd0);
      end
    end
    hold_n = 1'b1;
    wait_bv(7, 200);
    check("byte_gap_hold", 32'((t_last - t_prev) / 10), 32'd36);

    hdr_q.push_back(16'hFFFE);
    exp_q.push_back('{a: 16'hFFFE, d: 8'h5B});
    exp_q.push_back('{a: 16'hFFFF, d: 8'h5A});
    exp_q.push_back('{a: 16'h0000, d: 8'hA5});
    start_addr = 16'hFFFE;
    restart = 1'b1;
    step();
    restart = 1'b0;
    wait_bv(10, 300);

    k = 0;
    while (sck != 1'b1 && k < 50) begin
      step();
      k++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    check("pending_bytes", 32'(exp_q.size()), 32'd0);
    check("pending_headers", 32'(hdr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vslc_spi_eeprom_fetch.md
Name: vslc_spi_eeprom_fetch

Overview:
- SPI-mode-0 sequential reader for a 25xx-series serial EEPROM; sits directly upstream of the VSLC core.
- Issues READ (0x03) plus a 16-bit start address, then streams program bytes with a one-cycle valid strobe and the byte's address.
- The core uses these bytes for header parsing (addresses 0–3) and instruction execution.
- Runs entirely on the system clock; SCK is derived from a programmable clock-enable divider, not from a separate clock.

Parameters:
- ADDR_W, 16, EEPROM address width in bits; also the width of start_addr and byte_addr.
- CMD_READ, 8'h03, opcode shifted out first.
- GAP_TICKS, 2, minimum number of SCK half-period ticks cs_n is held high between transactions.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- spi_div  input  8  SCK half-period = spi_div+1 clk cycles; sampled at every tick
- restart  input  1  single-clk pulse; abort the current stream and re-read from start_addr
- start_addr  input  ADDR_W  first address to read; captured on reset release and on restart
- hold_n  input  1  low = pause streaming without deasserting cs_n
- cipo  input  1  serial data from EEPROM
- copi  output  1  serial data to EEPROM
- sck  output  1  SPI clock, idles low
- cs_n  output  1  EEPROM chip select, active low
- sd_oe  output  1  output-enable for a shared 3-wire SD pin; 1 while driving the command/address phase
- byte_valid  output  1  one-clk strobe: byte_data and byte_addr are valid
- byte_data  output  8  last completed byte, MSB first on the wire; held until the next byte completes
- byte_addr  output  ADDR_W  EEPROM address of byte_data
- bit_index  output  4  bits completed in the current field (0–7 in DATA); drives the stack serialiser

Behaviour:
- Reset values (async): cs_n=1, sck=0, copi=0, sd_oe=0, byte_valid=0, byte_data=0, byte_addr=0, bit_index=0. State=GAP, address register=start_addr, divider=0.
- Tick: the divider counts 0..spi_div; a tick fires on the clk where it equals spi_div, then it clears. spi_div=0 gives a tick every clk. Every tick in CMD/ADDR/DATA toggles sck.
- States: GAP -> CMD -> ADDR -> DATA (loops), plus HOLD.
- GAP: cs_n=1, sck=0. After GAP_TICKS ticks: go to CMD, cs_n=0, copi=CMD_READ[7], sd_oe=1.
- Mode 0: cipo is sampled on each sck 0->1 tick. copi advances to the next bit on each sck 1->0 tick.
- CMD: 8 bits, MSB first. ADDR: ADDR_W bits of the captured address, MSB first.
- After the last ADDR bit's falling edge: sd_oe=0, copi=0, state=DATA.
- DATA: on the 8th rising edge of a byte, the following happen on the next clk:
  - byte_data <= shifted byte; byte_addr <= current address; byte_valid=1 for exactly one clk.
  - Current address increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000); bit_index returns to 0.
- bit_index counts rising edges within the current field: CMD 0–7, ADDR 0–15, DATA 0–7.
- hold_n: sampled only at a tick where sck would rise. If low, enter HOLD:
  - sck stays 0, cs_n stays 0, bit and shift state frozen, no byte_valid.
  - Resume in the prior state at the first tick with hold_n=1.
- restart (any state, including HOLD):
  - Capture start_addr, force cs_n=1 and sck=0 on the next clk, enter GAP.
  - A partial byte is discarded with no byte_valid. Divider and bit_index clear.
- restart on the same clk a byte completes: that byte's byte_valid is still emitted; the restart takes effect on the same edge.
- Minimum restart-to-first-byte: GAP_TICKS + 2*(8+ADDR_W+8) ticks.
- byte_valid never asserts in GAP, CMD, ADDR or HOLD.

Test Plan:
- Reset release, spi_div=0, start_addr=0x0000, model returns 0xA5, 0x3C: expect cs_n low after 2 clks. copi shows 0x03 then 0x0000 MSB-first with sd_oe=1. Expect byte_valid with data 0xA5 / addr 0x0000, then 0x3C / addr 0x0001, 16 clks apart.
- spi_div=3: sck high and low phases are each exactly 4 clks. Consecutive byte_valid strobes are 64 clks apart.
- restart pulsed at bit_index=4 of byte 2, new start_addr=0x0123: expect no byte_valid for the partial byte and cs_n high ≥2 ticks. Expect address 0x0123 on copi, then first byte_addr=0x0123.
- hold_n low for 20 clks mid-byte: sck stays 0, cs_n stays 0, bit_index frozen. The byte completes with correct data after resume; total delay is +20 clks.
- start_addr=0xFFFE, stream 3 bytes: byte_addr sequence 0xFFFE, 0xFFFF, 0x0000.
- Async reset asserted mid-DATA without a clk edge: all outputs at reset values immediately.
